// File: rtl/bin_morph_bbox_5x5.sv
// Binary 5x5 morphology (bypass/erode/dilate/majority) on the matrix stream,
// plus per-frame bounding box of foreground pixels.
`timescale 1ns/1ps
module bin_morph_bbox_5x5 #(
    parameter logic [9:0] IMG_HDISP  = 10'd640,
    parameter logic [9:0] IMG_VDISP  = 10'd480,
    parameter logic [4:0] MAJ_THRESH = 5'd13
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        matrix_frame_vsync,
    input  logic        matrix_frame_href,
    input  logic        matrix_frame_clken,
    input  logic [24:0] matrix_bits,
    input  logic [1:0]  morph_mode,
    output logic        post_frame_vsync,
    output logic        post_frame_href,
    output logic        post_frame_clken,
    output logic        post_img_Bit,
    output logic [9:0]  bbox_xmin,
    output logic [9:0]  bbox_xmax,
    output logic [9:0]  bbox_ymin,
    output logic [9:0]  bbox_ymax,
    output logic        bbox_found,
    output logic        bbox_valid
);

    typedef enum logic {IDLE, ACTIVE} state_t;

    state_t      state_q, state_d;
    logic [4:0]  pop_c, pop;
    logic        ctr, filt;
    logic [1:0]  mode_r;
    logic        vs1, hr1, ce1;
    logic [9:0]  x_cnt, y_cnt;
    logic        href_d, vsync_d;
    logic [1:0]  fill;
    logic        seen_low;
    logic        vs_rise, vs_fall, fg;
    logic        start, latch;
    logic [9:0]  acc_xmin, acc_xmax, acc_ymin, acc_ymax;
    logic        acc_found;
    logic [9:0]  nxt_xmin, nxt_xmax, nxt_ymin, nxt_ymax;
    logic        nxt_found;

    always_comb begin
        pop_c = 5'd0;
        for (int i = 0; i < 25; i++) begin
            pop_c = pop_c + {4'd0, matrix_bits[i]};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pop    <= 5'd0;
            ctr    <= 1'b0;
            mode_r <= 2'b00;
            vs1    <= 1'b0;
            hr1    <= 1'b0;
            ce1    <= 1'b0;
        end else begin
            pop    <= pop_c;
            ctr    <= matrix_bits[12];
            mode_r <= morph_mode;
            vs1    <= matrix_frame_vsync;
            hr1    <= matrix_frame_href;
            ce1    <= matrix_frame_clken;
        end
    end

    always_comb begin
        filt = 1'b0;
        unique case (mode_r)
            2'b00:   filt = ctr;
            2'b01:   filt = (pop == 5'd25);
            2'b10:   filt = (pop != 5'd0);
            default: filt = (pop >= MAJ_THRESH);
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            post_frame_vsync <= 1'b0;
            post_frame_href  <= 1'b0;
            post_frame_clken <= 1'b0;
            post_img_Bit     <= 1'b0;
        end else begin
            post_frame_vsync <= vs1;
            post_frame_href  <= hr1;
            post_frame_clken <= ce1;
            post_img_Bit     <= hr1 & filt;
        end
    end

    // Coordinates of the pixel currently on the post_* strobes
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            x_cnt   <= 10'd0;
            y_cnt   <= 10'd0;
            href_d  <= 1'b0;
            vsync_d <= 1'b0;
        end else begin
            href_d  <= post_frame_href;
            vsync_d <= post_frame_vsync;
            if (!post_frame_href)
                x_cnt <= 10'd0;
            else if (post_frame_clken && x_cnt != IMG_HDISP - 10'd1)
                x_cnt <= x_cnt + 10'd1;
            if (!post_frame_vsync)
                y_cnt <= 10'd0;
            else if (href_d && !post_frame_href && y_cnt != IMG_VDISP - 10'd1)
                y_cnt <= y_cnt + 10'd1;
        end
    end

    // A vsync rise only counts once a genuine low has passed the refilled pipeline
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fill     <= 2'b00;
            seen_low <= 1'b0;
        end else begin
            fill <= {fill[0], 1'b1};
            if (fill[1] && !post_frame_vsync)
                seen_low <= 1'b1;
        end
    end

    assign vs_rise = post_frame_vsync & ~vsync_d & seen_low;
    assign vs_fall = ~post_frame_vsync & vsync_d;
    assign fg = post_frame_vsync & post_frame_href & post_frame_clken & post_img_Bit;

    always_comb begin
        state_d = state_q;
        start   = 1'b0;
        latch   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (vs_rise) begin
                    start   = 1'b1;
                    state_d = ACTIVE;
                end
            end
            default: begin
                if (vs_fall) begin
                    latch   = 1'b1;
                    state_d = IDLE;
                end else if (vs_rise) begin
                    start = 1'b1;
                end
            end
        endcase
    end

    always_comb begin
        nxt_xmin  = start ? IMG_HDISP - 10'd1 : acc_xmin;
        nxt_ymin  = start ? IMG_VDISP - 10'd1 : acc_ymin;
        nxt_xmax  = start ? 10'd0 : acc_xmax;
        nxt_ymax  = start ? 10'd0 : acc_ymax;
        nxt_found = start ? 1'b0 : acc_found;
        if (fg && (start || state_q == ACTIVE)) begin
            nxt_found = 1'b1;
            if (x_cnt < nxt_xmin) nxt_xmin = x_cnt;
            if (x_cnt > nxt_xmax) nxt_xmax = x_cnt;
            if (y_cnt < nxt_ymin) nxt_ymin = y_cnt;
            if (y_cnt > nxt_ymax) nxt_ymax = y_cnt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            acc_xmin  <= 10'd0;
            acc_xmax  <= 10'd0;
            acc_ymin  <= 10'd0;
            acc_ymax  <= 10'd0;
            acc_found <= 1'b0;
        end else begin
            state_q   <= state_d;
            acc_xmin  <= nxt_xmin;
            acc_xmax  <= nxt_xmax;
            acc_ymin  <= nxt_ymin;
            acc_ymax  <= nxt_ymax;
            acc_found <= nxt_found;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bbox_xmin  <= 10'd0;
            bbox_xmax  <= 10'd0;
            bbox_ymin  <= 10'd0;
            bbox_ymax  <= 10'd0;
            bbox_found <= 1'b0;
            bbox_valid <= 1'b0;
        end else begin
            bbox_valid <= latch;
            if (latch) begin
                bbox_xmin  <= acc_found ? acc_xmin : 10'd0;
                bbox_xmax  <= acc_found ? acc_xmax : 10'd0;
                bbox_ymin  <= acc_found ? acc_ymin : 10'd0;
                bbox_ymax  <= acc_found ? acc_ymax : 10'd0;
                bbox_found <= acc_found;
            end
        end
    end

endmodule

// File: tb/tb_bin_morph_bbox_5x5.sv
// Bench for bin_morph_bbox_5x5: filter vector table, latency sequence,
// random stream against a reference model, and bounding-box frames.
`timescale 1ns/1ps
module tb_bin_morph_bbox_5x5;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        vs = 1'b0, hr = 1'b0, ce = 1'b0;
    logic [24:0] bits = 25'd0;
    logic [1:0]  mode = 2'b00;
    logic        post_vs, post_hr, post_ce, post_bit;
    logic [9:0]  xmin, xmax, ymin, ymax;
    logic        found, valid;

    int n_vec = 0;
    int n_err = 0;

    bin_morph_bbox_5x5 dut (
        .clk(clk), .rst(rst),
        .matrix_frame_vsync(vs), .matrix_frame_href(hr),
        .matrix_frame_clken(ce), .matrix_bits(bits),
        .morph_mode(mode),
        .post_frame_vsync(post_vs), .post_frame_href(post_hr),
        .post_frame_clken(post_ce), .post_img_Bit(post_bit),
        .bbox_xmin(xmin), .bbox_xmax(xmax),
        .bbox_ymin(ymin), .bbox_ymax(ymax),
        .bbox_found(found), .bbox_valid(valid)
    );

    always #5 clk = ~clk;

    task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic model(logic [24:0] b, logic [1:0] m);
        int p;
        p = $countones(b);
        case (m)
            2'd0:    return b[12];
            2'd1:    return p == 25;
            2'd2:    return p != 0;
            default: return p >= 13;
        endcase
    endfunction

    // Stream reference: outputs equal the inputs of two edges earlier
    typedef struct packed {
        logic        vs, hr, ce;
        logic [24:0] b;
        logic [1:0]  m;
    } smp_t;

    smp_t cur = '0;
    smp_t prv = '0;

    always @(posedge clk) begin
        if (rst) begin
            cur <= '0;
            prv <= '0;
        end else begin
            prv <= cur;
            cur <= {vs, hr, ce, bits, mode};
        end
    end

    always @(negedge clk) begin
        logic [3:0] e;
        e = rst ? 4'b0000
                : {prv.hr & model(prv.b, prv.m), prv.vs, prv.hr, prv.ce};
        chk("stream", {post_bit, post_vs, post_hr, post_ce}, e);
    end

    typedef struct {
        logic [1:0]  m;
        logic [24:0] b;
        logic        e;
    } vec_t;

    vec_t tbl[14];

    task automatic run_frame(string nm, int w, int h, int kind,
                             logic [1:0] m, int bx0, int bx1,
                             int by0, int by1, int rst_line,
                             bit exp_valid);
        int exmin, exmax, eymin, eymax, cnt;
        bit ef;
        logic [24:0] b;
        exmin = 639; eymin = 479; exmax = 0; eymax = 0; ef = 0;
        @(posedge clk); #1;
        vs = 1; hr = 0; ce = 0; mode = m;
        repeat (3) @(posedge clk);
        for (int l = 0; l < h; l++) begin
            for (int c = 0; c < w; c++) begin
                @(posedge clk); #1;
                hr = 1; ce = 1;
                b = 25'($urandom);
                if (kind == 0)
                    b[12] = (c >= bx0 && c <= bx1 && l >= by0 && l <= by1);
                else if ($urandom_range(0, 39) != 0)
                    b = 25'd0;
                bits = b;
                if (model(b, m)) begin
                    ef = 1;
                    if (c < exmin) exmin = c;
                    if (c > exmax) exmax = c;
                    if (l < eymin) eymin = l;
                    if (l > eymax) eymax = l;
                end
                if (l == rst_line && c == 2) begin
                    rst = 1;
                    @(negedge clk);
                    chk({nm, "_rst_out"},
                        {xmin, xmax, ymin, ymax, found, valid,
                         post_bit, post_vs, post_hr, post_ce}, 64'd0);
                end
                if (l == rst_line && c == 4)
                    rst = 0;
            end
            repeat (2) begin
                @(posedge clk); #1;
                hr = 0; ce = 0;
            end
        end
        @(posedge clk); #1;
        vs = 0;
        cnt = 0;
        while (cnt < 30) begin
            @(negedge clk);
            if (valid) break;
            cnt++;
        end
        chk({nm, "_valid_seen"}, (cnt < 30), exp_valid);
        if (exp_valid && cnt < 30) begin
            if (!ef) begin
                exmin = 0; exmax = 0; eymin = 0; eymax = 0;
            end
            chk({nm, "_xmin"}, xmin, exmin);
            chk({nm, "_xmax"}, xmax, exmax);
            chk({nm, "_ymin"}, ymin, eymin);
            chk({nm, "_ymax"}, ymax, eymax);
            chk({nm, "_found"}, found, ef);
            @(negedge clk);
            chk({nm, "_pulse1"}, valid, 0);
            repeat (5) @(negedge clk);
            chk({nm, "_hold"}, {xmin, xmax, found}, {10'(exmin), 10'(exmax), ef});
        end
        repeat (10) @(posedge clk);
    endtask

    initial begin
        tbl = '{
            '{2'd0, 25'h0001000, 1'b1},
            '{2'd0, 25'h1FFEFFF, 1'b0},
            '{2'd0, 25'h1FFFFFF, 1'b1},
            '{2'd1, 25'h1FFFFFF, 1'b1},
            '{2'd2, 25'h1FFFFFF, 1'b1},
            '{2'd3, 25'h1FFFFFF, 1'b1},
            '{2'd1, 25'h1FFFFFE, 1'b0},
            '{2'd2, 25'h1FFFFFE, 1'b1},
            '{2'd2, 25'h0000000, 1'b0},
            '{2'd2, 25'h1000000, 1'b1},
            '{2'd1, 25'h0000000, 1'b0},
            '{2'd3, 25'h0000FFF, 1'b0},
            '{2'd3, 25'h0001FFF, 1'b1},
            '{2'd3, 25'h1F00F0F, 1'b1}
        };

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_state",
            {xmin, xmax, ymin, ymax, found, valid,
             post_bit, post_vs, post_hr, post_ce}, 64'd0);
        @(posedge clk); #1;
        rst = 0;
        repeat (4) @(posedge clk);

        for (int i = 0; i < 14; i++) begin
            @(posedge clk); #1;
            vs = 1; hr = 1; ce = 1;
            bits = tbl[i].b;
            mode = tbl[i].m;
            @(posedge clk);
            @(posedge clk);
            @(negedge clk);
            chk($sformatf("tbl%0d", i), post_bit, tbl[i].e);
        end

        // Single clken beat must appear exactly two edges later
        @(posedge clk); #1;
        mode = 0; bits = 0; ce = 0;
        @(posedge clk); #1;
        ce = 1; bits = 25'h0001000;
        @(posedge clk); #1;
        ce = 0; bits = 0;
        @(negedge clk);
        chk("t1_lat1", {post_bit, post_ce}, 2'b00);
        @(negedge clk);
        chk("t1_lat2", {post_bit, post_ce}, 2'b11);
        @(negedge clk);
        chk("t1_lat3", {post_bit, post_ce}, 2'b00);

        // Href low forces the output low even with a full window
        @(posedge clk); #1;
        hr = 0; ce = 1; bits = 25'h1FFFFFF; mode = 2'd2;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("href_gate", post_bit, 0);

        for (int i = 0; i < 400; i++) begin
            @(posedge clk); #1;
            vs = 1'($urandom); hr = 1'($urandom); ce = 1'($urandom);
            mode = 2'($urandom_range(0, 3));
            case ($urandom_range(0, 3))
                0: bits = 25'h1FFFFFF;
                1: bits = 25'd0;
                2: bits = 25'h1FFFFFF ^ (25'd1 << $urandom_range(0, 24));
                default: bits = 25'($urandom);
            endcase
        end
        @(posedge clk); #1;
        vs = 0; hr = 0; ce = 0; bits = 0;
        repeat (40) @(posedge clk);

        run_frame("t4_box", 160, 225, 0, 2'd0, 100, 149, 200, 219, -1, 1);
        run_frame("t5_empty", 40, 20, 0, 2'd0, 1000, 1000, 1000, 1000, -1, 1);
        run_frame("rnd_frame", 40, 30, 1, 2'd2, 0, 0, 0, 0, -1, 1);
        run_frame("t6_abort", 6, 250, 0, 2'd0, 1, 3, 230, 245, 240, 0);
        run_frame("t6_next", 30, 20, 0, 2'd0, 5, 9, 3, 7, -1, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
